// File: rtl/comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   state_t  : FSM encoding (IDLE/SCAN/DONE), also driven out on the debug port
//   RES_*    : one-hot result codes, ordered {aeb, agb, alb}
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_EQ = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/comp1b3o.sv
// 1-bit three-output compare cell.
//   a, b : single operand bits
//   eq   : a == b
//   gt   : a > b  (a=1, b=0)
//   lt   : a < b  (a=0, b=1)
// Exactly one output is high for any input pair.
module comp1b3o (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake; a and b captured when both high
//   a, b                : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake; result held while out_valid=1
//   aeb, agb, alb       : registered one-hot result {a==b, a>b, a<b}
//   busy                : high in SCAN or DONE
//   dbg_state           : current FSM state (comp_pkg::state_t encoding)
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; a producer holds its data stable while valid is high and
// ready is low, and ready never depends on the same side's valid.
import comp_pkg::*;

module serial_mag_comp #(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             aeb,
  output logic             agb,
  output logic             alb,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]   cnt;
  logic            diff_seen;
  logic [2:0]      diff_res;
  logic [2:0]      res;

  logic cell_eq, cell_gt, cell_lt;
  logic [2:0] cell_res;
  logic differ;

  comp1b3o u_cell (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .eq (cell_eq),
    .gt (cell_gt),
    .lt (cell_lt)
  );

  // The cell outputs already form the one-hot result code for the current bit.
  assign cell_res = {cell_eq, cell_gt, cell_lt};
  assign differ   = (cell_res != RES_EQ);

  // Gated with rst so nothing is offered or reported busy during reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = ((state == SCAN) || (state == DONE)) && !rst;
  assign dbg_state = state;
  assign {aeb, agb, alb} = res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      diff_seen <= 1'b0;
      diff_res  <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa        <= a;
            sb        <= b;
            cnt       <= CNT_LOAD;
            diff_seen <= 1'b0;
            diff_res  <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (differ && EARLY_EXIT) begin
            res       <= cell_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CW'(1);
            // Sticky: only the most significant difference decides the result.
            if (differ && !diff_seen) begin
              diff_seen <= 1'b1;
              diff_res  <= cell_res;
            end
            if (cnt == '0) begin
              // The last bit's own difference is not yet in the sticky flag,
              // so fall back to the live cell result (RES_EQ when equal).
              res       <= diff_seen ? diff_res : cell_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: two instances (EARLY_EXIT=1 and EARLY_EXIT=0)
// share stimulus; each is checked against hand-computed result and latency.
import comp_pkg::*;

module tb_serial_mag_comp;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic in_ready_e, out_valid_e, aeb_e, agb_e, alb_e, busy_e;
  logic in_ready_f, out_valid_f, aeb_f, agb_f, alb_f, busy_f;
  logic [1:0] st_e, st_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e),
    .a(a), .b(b), .out_valid(out_valid_e), .out_ready(out_ready),
    .aeb(aeb_e), .agb(agb_e), .alb(alb_e), .busy(busy_e), .dbg_state(st_e)
  );

  serial_mag_comp #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .out_valid(out_valid_f), .out_ready(out_ready),
    .aeb(aeb_f), .agb(agb_f), .alb(alb_f), .busy(busy_f), .dbg_state(st_f)
  );

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [2:0]       exp;
    int               je;
    int               jf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offer one pair, then watch both instances for WIDTH+3 cycles with
  // out_ready high; record the cycle out_valid first rises and the result.
  task automatic run_pair(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic [2:0] exp, input int je, input int jf);
    int got_je = -1;
    int got_jf = -1;
    logic [2:0] res_e = '0;
    logic [2:0] res_f = '0;
    out_ready = 1'b1;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    check("in_ready_e", 32'(in_ready_e), 1);
    check("in_ready_f", 32'(in_ready_f), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom_range(0, 15));
    b = WIDTH'($urandom_range(0, 15));
    check("busy_e", 32'(busy_e), 1);
    for (int c = 1; c <= WIDTH + 3; c++) begin
      @(posedge clk); #1;
      if (out_valid_e && got_je < 0) begin
        got_je = c; res_e = {aeb_e, agb_e, alb_e};
      end else if (out_valid_e) begin
        check("ov_e_once", 32'(out_valid_e), 0);
      end
      if (out_valid_f && got_jf < 0) begin
        got_jf = c; res_f = {aeb_f, agb_f, alb_f};
      end else if (out_valid_f) begin
        check("ov_f_once", 32'(out_valid_f), 0);
      end
    end
    check("lat_e", 32'(got_je), 32'(je));
    check("res_e", 32'(res_e), 32'(exp));
    check("lat_f", 32'(got_jf), 32'(jf));
    check("res_f", 32'(res_f), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{4'b1000, 4'b0111, RES_GT, 1, 4};
    vecs[1] = '{4'b0101, 4'b0101, RES_EQ, 4, 4};
    vecs[2] = '{4'b0010, 4'b0011, RES_LT, 4, 4};
    vecs[3] = '{4'b0100, 4'b0110, RES_LT, 3, 4};
    vecs[4] = '{4'b1111, 4'b1011, RES_GT, 2, 4};
    vecs[5] = '{4'b0000, 4'b1111, RES_LT, 1, 4};
    vecs[6] = '{4'b1111, 4'b1111, RES_EQ, 4, 4};
    vecs[7] = '{4'b0001, 4'b0000, RES_GT, 4, 4};
    vecs[8] = '{4'b0110, 4'b0101, RES_GT, 3, 4};
    vecs[9] = '{4'b1000, 4'b1001, RES_LT, 4, 4};

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = '0; b = '0;

    // Reset held for 3 cycles; in_valid high must not be accepted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid_e), 0);
      check("rst_res", 32'({aeb_e, agb_e, alb_e}), 0);
      check("rst_in_ready", 32'(in_ready_e), 0);
      check("rst_busy", 32'(busy_e), 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready_e", 32'(in_ready_e), 1);
    check("post_rst_in_ready_f", 32'(in_ready_f), 1);
    check("post_rst_state", 32'(st_e), 32'(IDLE));

    // Table of directed vectors.
    for (int i = 0; i < 10; i++)
      run_pair(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].je, vecs[i].jf);

    // Backpressure: out_ready low for 5 cycles after the early-exit result.
    out_ready = 1'b0;
    @(negedge clk);
    a = 4'b1000; b = 4'b0111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_rise", 32'(out_valid_e), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); a = 4'b0000; b = 4'b1111;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid_e), 1);
      check("bp_res", 32'({aeb_e, agb_e, alb_e}), 32'(RES_GT));
      check("bp_in_ready", 32'(in_ready_e), 0);
    end
    check("bp_valid_f", 32'(out_valid_f), 1);
    check("bp_res_f", 32'({aeb_f, agb_f, alb_f}), 32'(RES_GT));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_e", 32'(out_valid_e), 0);
    check("bp_release_f", 32'(out_valid_f), 0);
    check("bp_idle_ready", 32'(in_ready_e), 1);
    check("bp_res_held", 32'({aeb_e, agb_e, alb_e}), 32'(RES_GT));
    @(posedge clk); #1;
    check("bp_one_handshake", 32'(out_valid_e), 0);

    // Reset two cycles after accepting an equal pair (mid-SCAN).
    @(negedge clk);
    a = 4'b0101; b = 4'b0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_rst_state_e", 32'(st_e), 32'(IDLE));
    check("mid_rst_state_f", 32'(st_f), 32'(IDLE));
    check("mid_rst_res", 32'({aeb_e, agb_e, alb_e}), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_e || out_valid_f)
        check("mid_rst_no_result", 32'(out_valid_e | out_valid_f), 0);
    end
    check("mid_rst_still_idle", 32'(st_f), 32'(IDLE));
    run_pair(4'b0010, 4'b0011, RES_LT, 4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
